// File: rtl/key_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
// Holds the matrix geometry, the row-index state type, the board-label key
// codes, and the priority encoder that the event emitter uses.
package key_pkg;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned KEYS  = 16;
    localparam int unsigned KEY_W = 4;

    // Row currently driven low.
    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } row_t;

    // Board silkscreen labels: code = row*4 + col.
    localparam logic [KEY_W-1:0] KEY_S4  = 4'd0;
    localparam logic [KEY_W-1:0] KEY_S5  = 4'd1;
    localparam logic [KEY_W-1:0] KEY_S6  = 4'd2;
    localparam logic [KEY_W-1:0] KEY_S7  = 4'd3;
    localparam logic [KEY_W-1:0] KEY_S8  = 4'd4;
    localparam logic [KEY_W-1:0] KEY_S9  = 4'd5;
    localparam logic [KEY_W-1:0] KEY_S10 = 4'd6;
    localparam logic [KEY_W-1:0] KEY_S11 = 4'd7;
    localparam logic [KEY_W-1:0] KEY_S12 = 4'd8;
    localparam logic [KEY_W-1:0] KEY_S13 = 4'd9;
    localparam logic [KEY_W-1:0] KEY_S14 = 4'd10;
    localparam logic [KEY_W-1:0] KEY_S15 = 4'd11;
    localparam logic [KEY_W-1:0] KEY_S16 = 4'd12;
    localparam logic [KEY_W-1:0] KEY_S17 = 4'd13;
    localparam logic [KEY_W-1:0] KEY_S18 = 4'd14;
    localparam logic [KEY_W-1:0] KEY_S19 = 4'd15;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [KEY_W-1:0] lowest_set(input logic [KEYS-1:0] mask);
        logic [KEY_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < KEYS; i++) begin
            if (!found && mask[i]) begin
                idx   = KEY_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Row-dwell divider for the keypad scanner.
// Counts 0..DIV-1 and raises tick for the single cycle the count sits at
// DIV-1, then wraps to 0. DIV must be at least 4.
//   clk  in   system clock
//   rst  in   synchronous active-high reset (count returns to 0)
//   tick out  one-cycle pulse every DIV cycles
module scan_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned      CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 matrix keypad scanner with frame debounce and press events.
// Drives one row low at a time, samples the synchronized columns at the end
// of each row dwell, and debounces the complete 16-key frame. Newly pressed
// keys are reported one per cycle, lowest code first.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   col_in     in   keypad columns, active-low, asynchronous
//   row_out    out  keypad row drive, active-low, one row low at a time
//   key_state  out  debounced pressed map, bit row*4+col, 1 = pressed
//   key_down   out  any key pressed in key_state
//   key_valid  out  one-cycle pulse per newly pressed key
//   key_code   out  code reported with key_valid, held otherwise
module key_matrix_scan
    import key_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned SCAN_HZ        = 1_000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [COLS-1:0]  col_in,
    output logic [ROWS-1:0]  row_out,
    output logic [KEYS-1:0]  key_state,
    output logic             key_down,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code
);

    localparam int unsigned DIV = CLK_FREQ / SCAN_HZ;
    localparam logic [3:0]  DEB = 4'(DEBOUNCE_SCANS);

    logic tick;

    scan_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Column synchronizer
    logic [COLS-1:0] sync1_q, sync1_d;
    logic [COLS-1:0] col_s_q, col_s_d;

    // Row scan state
    row_t            row_q, row_d;
    logic [ROWS-1:0] row_out_q, row_out_d;

    // Frame debounce
    logic [KEYS-1:0] frame_q, frame_d;
    logic [KEYS-1:0] prev_frame_q, prev_frame_d;
    logic [3:0]      stable_q, stable_d;
    logic [KEYS-1:0] new_state_q, new_state_d;
    logic            update_q, update_d;
    logic [KEYS-1:0] key_state_q, key_state_d;

    // Event emitter
    logic [KEYS-1:0]  pending_q, pending_d;
    logic [KEYS-1:0]  pending_set;
    logic             key_valid_q, key_valid_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;

    always_comb begin
        sync1_d = col_in;
        col_s_d = sync1_q;
    end

    // Scan and debounce. The frame is assembled in frame_d so the row-3
    // sample is already included when the completed frame is compared.
    always_comb begin
        row_d        = row_q;
        row_out_d    = row_out_q;
        frame_d      = frame_q;
        prev_frame_d = prev_frame_q;
        stable_d     = stable_q;
        new_state_d  = new_state_q;
        update_d     = 1'b0;
        pending_set  = '0;
        key_state_d  = update_q ? new_state_q : key_state_q;

        if (tick) begin
            frame_d[int'(row_q)*COLS +: COLS] = ~col_s_q;
            row_d     = row_t'(row_q + 2'd1);
            row_out_d = ~(ROWS'(1) << row_d);

            if (row_q == ROW3) begin
                prev_frame_d = frame_d;
                if (frame_d == prev_frame_q) begin
                    stable_d = (stable_q >= DEB) ? DEB : stable_q + 4'd1;
                end else begin
                    stable_d = 4'd1;
                end
                if (stable_d == DEB) begin
                    new_state_d = frame_d;
                    update_d    = 1'b1;
                    pending_set = frame_d & ~key_state_q;
                end
            end
        end
    end

    // One event per cycle, lowest code first. Bits stay pending even if the
    // key is released before its turn.
    always_comb begin
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        pending_d   = pending_q | pending_set;
        if (pending_q != '0) begin
            key_valid_d = 1'b1;
            key_code_d  = lowest_set(pending_q);
            pending_d   = (pending_q & ~(KEYS'(1) << key_code_d)) | pending_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '1;
            col_s_q      <= '1;
            row_q        <= ROW0;
            row_out_q    <= 4'b1110;
            frame_q      <= '0;
            prev_frame_q <= '0;
            stable_q     <= '0;
            new_state_q  <= '0;
            update_q     <= 1'b0;
            key_state_q  <= '0;
            pending_q    <= '0;
            key_valid_q  <= 1'b0;
            key_code_q   <= '0;
        end else begin
            sync1_q      <= sync1_d;
            col_s_q      <= col_s_d;
            row_q        <= row_d;
            row_out_q    <= row_out_d;
            frame_q      <= frame_d;
            prev_frame_q <= prev_frame_d;
            stable_q     <= stable_d;
            new_state_q  <= new_state_d;
            update_q     <= update_d;
            key_state_q  <= key_state_d;
            pending_q    <= pending_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
        end
    end

    assign row_out   = row_out_q;
    assign key_state = key_state_q;
    assign key_down  = |key_state_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule
